pattern_tx: RTL

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_tx_if.sv | 25 ++
 rtl/pattern_tx.sv | 117 +++++++++++
 2 files changed

// File: rtl/pattern_tx_if.sv
// Control and serial-output bundle for pattern_tx: burst request fields in,
// serial bit stream and status out.
interface pattern_tx_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             use_const;
  logic [WIDTH-1:0] data_in;
  logic [3:0]       reps;
  logic             sdo;
  logic             sdo_valid;
  logic             frame;
  logic             busy;
  logic             done;

  modport master (
    output start, use_const, data_in, reps,
    input  sdo, sdo_valid, frame, busy, done
  );

  modport slave (
    input  start, use_const, data_in, reps,
    output sdo, sdo_valid, frame, busy, done
  );
endinterface

// File: rtl/pattern_tx.sv
// Burst serialiser: sends a latched word (or the PATTERN constant) MSB first,
// repeated reps times with one-cycle gaps, then pulses done.
module pattern_tx #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b0101
) (
  input  logic         clk,
  input  logic         rst_n,
  pattern_tx_if.slave  bus
);

  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       rel_sync;
  logic             ready;
  logic [WIDTH-1:0] word_lat;
  logic [WIDTH-1:0] sreg_p0;
  logic [3:0]       reps_lat;
  logic [3:0]       word_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             last_bit;
  logic             more_words;
  logic             accept;
  logic             sdo_p1;
  logic             vld_p1;
  logic             frame_p1;
  logic             done_p1;

  assign ready      = rel_sync[1];
  assign last_bit   = (bit_cnt == BW'(WIDTH - 1));
  assign more_words = (word_cnt < reps_lat);
  // The done pulse still counts as busy, so a request during it is dropped.
  assign accept     = ready & ~done_p1 & bus.start;

  // Reset release is re-timed so the FSM never starts on a partial edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel_sync <= 2'b00;
    else        rel_sync <= {rel_sync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = more_words ? GAP : DONE;
      GAP:     state_nxt = SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request capture, shift register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_lat <= '0;
      reps_lat <= '0;
      sreg_p0  <= '0;
      word_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word_lat <= bus.use_const ? PATTERN : bus.data_in;
            reps_lat <= (bus.reps == 4'd0) ? 4'd1 : bus.reps;
          end
        end
        LOAD: begin
          sreg_p0  <= word_lat;
          bit_cnt  <= '0;
          word_cnt <= 4'd1;
        end
        SHIFT: begin
          sreg_p0 <= sreg_p0 << 1;
          bit_cnt <= bit_cnt + BW'(1);
        end
        GAP: begin
          sreg_p0  <= word_lat;
          bit_cnt  <= '0;
          word_cnt <= word_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: registered serial outputs, one cycle behind the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdo_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      frame_p1 <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      sdo_p1   <= (state == SHIFT) & sreg_p0[WIDTH-1];
      vld_p1   <= (state == SHIFT);
      frame_p1 <= (state == SHIFT) & (bit_cnt == '0);
      done_p1  <= (state == DONE);
    end
  end

  assign bus.sdo       = sdo_p1;
  assign bus.sdo_valid = vld_p1;
  assign bus.frame     = frame_p1;
  assign bus.done      = done_p1;
  assign bus.busy      = (state != IDLE) | done_p1;

endmodule
